// File: rtl/arbitro_rr.sv
// Round-robin arbiter moving words from 4 input FIFOs to 4 output FIFOs.
// Ports:
//   clk, reset              : clock and synchronous active-high reset
//   enable                  : arbitration allowed (from transaction FSM)
//   in_empty, in_data0..3   : input FIFO empty flags and FWFT head words
//   out_almost_full         : output FIFO almost-full flags (global stall)
//   pop_in                  : one-hot combinational pop strobe
//   push_out, data_out      : registered one-hot push strobe and word
//   grant, state            : last input served, FSM state
module arbitro_rr #(
   parameter int WORD_SIZE = 10,
   parameter int NUM_PORTS = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [NUM_PORTS-1:0] in_empty,
   input  logic [WORD_SIZE-1:0] in_data0,
   input  logic [WORD_SIZE-1:0] in_data1,
   input  logic [WORD_SIZE-1:0] in_data2,
   input  logic [WORD_SIZE-1:0] in_data3,
   input  logic [NUM_PORTS-1:0] out_almost_full,
   output logic [NUM_PORTS-1:0] pop_in,
   output logic [NUM_PORTS-1:0] push_out,
   output logic [WORD_SIZE-1:0] data_out,
   output logic [1:0]           grant,
   output logic [1:0]           state
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [1:0]             grant_q, grant_d;
   logic [WORD_SIZE-1:0]   data_q, data_d;
   logic [NUM_PORTS-1:0]   push_q, push_d;

   logic                   stall;
   logic                   eligible;
   logic                   found;
   logic [1:0]             sel;
   logic [1:0]             idx;
   logic [WORD_SIZE-1:0]   head;

   assign stall    = |out_almost_full;
   assign eligible = enable & ~stall & ~(&in_empty) & ~reset;

   // Search starts just after the last served port and wraps
   // around so the last served port has the lowest priority.
   always_comb begin
      sel   = grant_q;
      found = 1'b0;
      idx   = grant_q;
      for (int k = 1; k <= 4; k++) begin
         idx = grant_q + 2'(k);
         if (!found && !in_empty[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      head = '0;
      case (sel)
         2'd0: head = in_data0;
         2'd1: head = in_data1;
         2'd2: head = in_data2;
         2'd3: head = in_data3;
         default: head = '0;
      endcase
   end

   assign pop_in = eligible ? (NUM_PORTS'(1) << sel) : '0;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      data_d  = data_q;
      push_d  = '0;
      if (!enable) begin
         state_d = IDLE;
      end else if (stall) begin
         state_d = HOLD;
      end else begin
         state_d = RUN;
      end
      if (eligible) begin
         grant_d = sel;
         data_d  = head;
         push_d  = NUM_PORTS'(1) << head[WORD_SIZE-1 -: 2];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= 2'd3;
         data_q  <= '0;
         push_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         data_q  <= data_d;
         push_q  <= push_d;
      end
   end

   assign push_out = push_q;
   assign data_out = data_q;
   assign grant    = grant_q;
   assign state    = state_q;

endmodule

// File: tb/tb_arbitro_rr.sv
// Bench for arbitro_rr: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a reference model.
module tb_arbitro_rr;

   localparam int WS = 10;

   logic          clk;
   logic          reset;
   logic          enable;
   logic [3:0]    in_empty;
   logic [WS-1:0] hd [4];
   logic [3:0]    af;
   logic [3:0]    pop_in;
   logic [3:0]    push_out;
   logic [WS-1:0] data_out;
   logic [1:0]    grant;
   logic [1:0]    state;

   int checks;
   int failures;

   arbitro_rr #(.WORD_SIZE(WS), .NUM_PORTS(4)) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .in_empty(in_empty),
      .in_data0(hd[0]),
      .in_data1(hd[1]),
      .in_data2(hd[2]),
      .in_data3(hd[3]),
      .out_almost_full(af),
      .pop_in(pop_in),
      .push_out(push_out),
      .data_out(data_out),
      .grant(grant),
      .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                  $time);
      end
   endtask

   // Reference model: registered outputs as the spec describes them.
   bit      m_valid;
   int      m_grant;
   int      m_data;
   int      m_push;
   int      m_state;

   // Returns the port to pop, or -1 when no pop may happen.
   function automatic int m_pick();
      int p;
      if (reset || !enable || af != 4'h0 || in_empty == 4'hF)
         return -1;
      for (int off = 1; off <= 4; off++) begin
         p = (m_grant + off) % 4;
         if (!in_empty[p]) return p;
      end
      return -1;
   endfunction

   always @(negedge clk) begin
      int p;
      int ep;
      p  = m_pick();
      ep = (p < 0) ? 0 : (1 << p);
      if (m_valid) begin
         chk("m_pop", {28'h0, pop_in}, ep);
         chk("m_push", {28'h0, push_out}, m_push);
         chk("m_data", {22'h0, data_out}, m_data);
         chk("m_grant", {30'h0, grant}, m_grant);
         chk("m_state", {30'h0, state}, m_state);
      end
      if (reset) begin
         m_valid = 1'b1;
         m_grant = 3;
         m_data  = 0;
         m_push  = 0;
         m_state = 0;
      end else begin
         if (p >= 0) begin
            m_grant = p;
            m_data  = int'(hd[p]);
            m_push  = 1 << (m_data / (2 ** (WS - 2)));
         end else begin
            m_push = 0;
         end
         m_state = !enable ? 0 : (af != 4'h0) ? 2 : 1;
      end
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic rnd_inputs();
      enable   = ($urandom_range(0, 4) != 0);
      in_empty = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
      af       = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      for (int i = 0; i < 4; i++) hd[i] = WS'($urandom);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      m_valid  = 1'b0;
      m_grant  = 0;
      m_data   = 0;
      m_push   = 0;
      m_state  = 0;

      reset = 1'b1;
      rnd_inputs();
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("rst_pop", {28'h0, pop_in}, 32'h0);
         chk("rst_push", {28'h0, push_out}, 32'h0);
         chk("rst_data", {22'h0, data_out}, 32'h0);
         chk("rst_grant", {30'h0, grant}, 32'd3);
         chk("rst_state", {30'h0, state}, 32'd0);
         nxt();
         rnd_inputs();
      end

      reset    = 1'b0;
      enable   = 1'b1;
      af       = 4'h0;
      in_empty = 4'b1110;
      hd[0]    = 10'h0A6;
      @(negedge clk);
      chk("single_pop", {28'h0, pop_in}, 32'h1);
      nxt();
      in_empty = 4'hF;
      @(negedge clk);
      chk("single_push", {28'h0, push_out}, 32'h1);
      chk("single_data", {22'h0, data_out}, 32'h0A6);
      chk("single_grant", {30'h0, grant}, 32'd0);
      nxt();

      reset    = 1'b1;
      in_empty = 4'h0;
      hd[0]    = 10'h0A6;
      hd[1]    = 10'h145;
      hd[2]    = 10'h278;
      hd[3]    = 10'h389;
      nxt();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rr_pop", {28'h0, pop_in}, 32'(1 << (i % 4)));
         if (i > 0) begin
            chk("rr_grant", {30'h0, grant}, 32'((i - 1) % 4));
            chk("rr_push", {28'h0, push_out}, 32'(1 << ((i - 1) % 4)));
         end
         nxt();
      end

      @(negedge clk);
      chk("pre_stall_pop", {28'h0, pop_in}, 32'b0010);
      nxt();
      af = 4'b0100;
      @(negedge clk);
      chk("stall_pop", {28'h0, pop_in}, 32'h0);
      chk("stall_pending_push", {28'h0, push_out}, 32'b0010);
      chk("stall_grant", {30'h0, grant}, 32'd1);
      nxt();
      @(negedge clk);
      chk("hold_state", {30'h0, state}, 32'd2);
      chk("hold_pop", {28'h0, pop_in}, 32'h0);
      chk("hold_push", {28'h0, push_out}, 32'h0);
      nxt();
      nxt();
      af = 4'h0;
      @(negedge clk);
      chk("release_pop", {28'h0, pop_in}, 32'b0100);
      nxt();

      enable = 1'b0;
      @(negedge clk);
      chk("dis_pop", {28'h0, pop_in}, 32'h0);
      chk("dis_push", {28'h0, push_out}, 32'b0100);
      chk("dis_grant", {30'h0, grant}, 32'd2);
      nxt();
      @(negedge clk);
      chk("idle_state", {30'h0, state}, 32'd0);
      chk("idle_pop", {28'h0, pop_in}, 32'h0);
      nxt();
      enable = 1'b1;
      @(negedge clk);
      chk("reen_pop", {28'h0, pop_in}, 32'b1000);
      nxt();

      reset = 1'b1;
      @(negedge clk);
      chk("rstfl_pop", {28'h0, pop_in}, 32'h0);
      chk("rstfl_push", {28'h0, push_out}, 32'b1000);
      chk("rstfl_data", {22'h0, data_out}, 32'h389);
      nxt();
      reset  = 1'b0;
      enable = 1'b0;
      @(negedge clk);
      chk("rstfl_after_push", {28'h0, push_out}, 32'h0);
      chk("rstfl_after_grant", {30'h0, grant}, 32'd3);
      chk("rstfl_after_state", {30'h0, state}, 32'd0);
      nxt();

      for (int c = 0; c < 800; c++) begin
         rnd_inputs();
         reset = ($urandom_range(0, 49) == 0);
         nxt();
      end
      reset = 1'b0;
      nxt();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
